prog_load_ctrl: RTL and testbench

Sequencer and port arbiter for the program-memory download path of the S86 SoC. It sits between the debounced program button, the UART program downloader and the CPU. It decides who owns the program-RAM write port and holds the CPU in reset while an image is loaded. It also runs a timed boot release after a load and aborts a stalled download.

---
 rtl/prog_load_ctrl.sv | 168 ++++++++++++++++
 tb/tb_prog_load_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_load_ctrl.sv
// ============================================================================
// Module   : prog_load_ctrl
// Brief    : Program-RAM port arbiter and load/boot sequencer for the S86 CPU.
//            Optional macro PGM_CKSUM_EN enables image checksum verification.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_load_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16384,
    parameter int BOOT_DLY = 16,
    parameter int IDLE_TO  = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              pg_wen,
    input  logic [ADDR_W-1:0] pg_adr,
    input  logic [DATA_W-1:0] pg_dat,
    input  logic              pg_done,
    input  logic              cpu_en,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_din,
    output logic              cpu_rst,
    output logic              upg_rst,
    output logic              load_busy,
    output logic              load_err,
    output logic [ADDR_W:0]   word_cnt,
    output logic [DATA_W-1:0] pg_sum
);

    localparam int BOOT_W = (BOOT_DLY > 1) ? $clog2(BOOT_DLY) : 1;
    localparam int IDLE_W = (IDLE_TO > 1) ? $clog2(IDLE_TO) : 1;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t              r_state;
    logic [BOOT_W-1:0]   r_boot_cnt;
    logic [IDLE_W-1:0]   r_idle_cnt;
    logic                r_started;
    logic                r_done_q;
    logic [DATA_W-1:0]   r_sum;

    logic                w_in_range;
    logic                w_wr_ok;
    logic                w_done_edge;
    logic                w_sum_ok;
    logic [DATA_W-1:0]   w_sum_next;

    assign w_in_range  = (32'(pg_adr) < DEPTH);
    assign w_wr_ok     = (r_state == ST_LOAD) && pg_wen && w_in_range;
    assign w_done_edge = pg_done && !r_done_q;

`ifdef PGM_CKSUM_EN
    // Sum includes a write landing in the same cycle as the done edge.
    assign w_sum_next = r_sum + (w_wr_ok ? pg_dat : '0);
    assign w_sum_ok   = (w_sum_next == '0);
`else
    assign w_sum_next = '0;
    assign w_sum_ok   = 1'b1;
`endif

    assign pg_sum = r_sum;

    always_comb begin
        if (r_state == ST_LOAD) begin
            mem_en  = pg_wen;
            mem_we  = pg_wen && w_in_range;
            mem_adr = pg_adr;
            mem_din = pg_dat;
        end else begin
            mem_en  = cpu_en;
            mem_we  = cpu_we;
            mem_adr = cpu_adr;
            mem_din = cpu_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_boot_cnt <= '0;
            r_idle_cnt <= '0;
            r_started  <= 1'b0;
            r_done_q   <= 1'b0;
            r_sum      <= '0;
            cpu_rst    <= 1'b1;
            upg_rst    <= 1'b1;
            load_busy  <= 1'b0;
            load_err   <= 1'b0;
            word_cnt   <= '0;
        end else begin
            r_done_q <= pg_done;
            case (r_state)
                ST_LOAD: begin
                    if (pg_wen) begin
                        r_idle_cnt <= '0;
                        if (w_in_range) begin
                            if (word_cnt != '1) begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                            r_started <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end else if (r_started) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                    r_sum <= w_sum_next;

                    if (w_done_edge) begin
                        upg_rst    <= 1'b1;
                        load_busy  <= 1'b0;
                        r_boot_cnt <= '0;
                        if (w_sum_ok) begin
                            r_state <= ST_BOOT;
                        end else begin
                            r_state  <= ST_HALT;
                            load_err <= 1'b1;
                        end
                    end else if (r_started && !pg_wen &&
                                 r_idle_cnt == IDLE_W'(IDLE_TO - 1)) begin
                        r_state   <= ST_HALT;
                        upg_rst   <= 1'b1;
                        load_busy <= 1'b0;
                        load_err  <= 1'b1;
                    end
                end
                default: begin
                    // BOOT, RUN and HALT all leave on a load request.
                    if (load_req) begin
                        r_state    <= ST_LOAD;
                        cpu_rst    <= 1'b1;
                        upg_rst    <= 1'b0;
                        load_busy  <= 1'b1;
                        load_err   <= 1'b0;
                        word_cnt   <= '0;
                        r_sum      <= '0;
                        r_idle_cnt <= '0;
                        r_started  <= 1'b0;
                    end else if (r_state == ST_BOOT) begin
                        if (r_boot_cnt == BOOT_W'(BOOT_DLY - 1)) begin
                            r_state <= ST_RUN;
                            cpu_rst <= 1'b0;
                        end else begin
                            r_boot_cnt <= r_boot_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prog_load_ctrl.sv
// ============================================================================
// Module   : tb_prog_load_ctrl
// Brief    : Self-checking bench for prog_load_ctrl against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_prog_load_ctrl;

    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 16;
    localparam int c_DEPTH  = 16384;
    localparam int c_BOOT   = 16;
    localparam int c_IDLE   = 50;
    localparam int c_CNTMAX = (1 << (c_ADDR_W + 1)) - 1;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_LOAD = 2;
    localparam int M_HALT = 3;

    logic                clk = 1'b0;
    logic                rst, load_req, pg_wen, pg_done;
    logic [c_ADDR_W-1:0] pg_adr, cpu_adr, mem_adr;
    logic [c_DATA_W-1:0] pg_dat, cpu_din, mem_din, pg_sum;
    logic                cpu_en, cpu_we, mem_en, mem_we;
    logic                cpu_rst, upg_rst, load_busy, load_err;
    logic [c_ADDR_W:0]   word_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int                  m_mode, m_age, m_silent, m_cnt;
    bit                  m_started, m_prev_done, m_err, m_live;
    logic [c_DATA_W-1:0] m_sum;
    bit                  pin_adr = 1'b0;

    prog_load_ctrl #(
        .ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W), .DEPTH(c_DEPTH),
        .BOOT_DLY(c_BOOT), .IDLE_TO(c_IDLE)
    ) dut (
        .clk(clk), .rst(rst), .load_req(load_req),
        .pg_wen(pg_wen), .pg_adr(pg_adr), .pg_dat(pg_dat), .pg_done(pg_done),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_din(cpu_din),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_din(mem_din),
        .cpu_rst(cpu_rst), .upg_rst(upg_rst), .load_busy(load_busy),
        .load_err(load_err), .word_cnt(word_cnt), .pg_sum(pg_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit edge_seen;
        if (rst) begin
            m_mode = M_BOOT; m_age = 0; m_silent = 0; m_started = 0;
            m_prev_done = 0; m_err = 0; m_cnt = 0; m_sum = '0; m_live = 1;
            return;
        end
        edge_seen   = pg_done && !m_prev_done;
        m_prev_done = pg_done;
        if (m_mode == M_LOAD) begin
            if (pg_wen) begin
                m_silent = 0;
                if (pg_adr < c_DEPTH) begin
                    if (m_cnt < c_CNTMAX) m_cnt++;
                    m_started = 1;
`ifdef PGM_CKSUM_EN
                    m_sum = m_sum + pg_dat;
`endif
                end else begin
                    m_err = 1;
                end
            end else if (m_started) begin
                m_silent++;
            end
            if (edge_seen) begin
                m_age = 0;
                if (m_sum == 0) m_mode = M_BOOT;
                else begin m_mode = M_HALT; m_err = 1; end
            end else if (m_started && m_silent >= c_IDLE) begin
                m_mode = M_HALT; m_err = 1;
            end
        end else if (load_req) begin
            m_mode = M_LOAD; m_err = 0; m_cnt = 0; m_sum = '0;
            m_silent = 0; m_started = 0;
        end else if (m_mode == M_BOOT) begin
            m_age++;
            if (m_age >= c_BOOT) m_mode = M_RUN;
        end
    endtask

    task automatic check_mux();
        bit ld;
        ld = (m_mode == M_LOAD);
        check("mem_en",  32'(mem_en),  32'(ld ? pg_wen : cpu_en));
        check("mem_we",  32'(mem_we),  32'(ld ? (pg_wen && pg_adr < c_DEPTH) : cpu_we));
        check("mem_adr", 32'(mem_adr), 32'(ld ? pg_adr : cpu_adr));
        check("mem_din", 32'(mem_din), 32'(ld ? pg_dat : cpu_din));
    endtask

    task automatic check_regs();
        check("cpu_rst",   32'(cpu_rst),   32'(m_mode != M_RUN));
        check("upg_rst",   32'(upg_rst),   32'(m_mode != M_LOAD));
        check("load_busy", 32'(load_busy), 32'(m_mode == M_LOAD));
        check("load_err",  32'(load_err),  32'(m_err));
        check("word_cnt",  32'(word_cnt),  32'(m_cnt));
        check("pg_sum",    32'(pg_sum),    32'(m_sum));
    endtask

    task automatic cyc(input bit r, input bit lr, input bit wen,
                       input logic [15:0] adr, input logic [15:0] dat, input bit done);
        rst = r; load_req = lr; pg_wen = wen; pg_adr = adr; pg_dat = dat; pg_done = done;
        cpu_en  = 1'($urandom);
        cpu_we  = 1'($urandom);
        cpu_adr = pin_adr ? 16'h0123 : 16'($urandom);
        cpu_din = 16'($urandom);
        @(negedge clk);
        if (m_live) check_mux();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic idle(input int n, input bit done);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'h0, 16'h0, done);
    endtask

    initial begin
        bit r, lr, wen, done_lvl;
        logic [15:0] adr;
        m_live = 0;
        m_mode = M_BOOT;

        // Reset, boot release and CPU pass-through
        repeat (3) cyc(1, 0, 0, 16'h0, 16'h0, 0);
        idle(c_BOOT + 4, 0);
        pin_adr = 1'b1;
        idle(2, 0);
        pin_adr = 1'b0;

        // Basic load of ten words then done
        cyc(0, 1, 0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 16'(i), 16'(i + 1), 0);
        idle(20, 1);
        idle(2, 0);

        // Out-of-range write
        cyc(0, 1, 0, 16'h0, 16'h0, 0);
        cyc(0, 0, 1, 16'h0005, 16'h1111, 0);
        cyc(0, 0, 1, 16'h4000, 16'h2222, 0);
        cyc(0, 0, 1, 16'h3FFF, 16'h3333, 0);
        cyc(0, 0, 0, 16'h0, 16'h0, 1);
        idle(3, 0);

        // Idle timeout, then recovery by a new request
        cyc(0, 1, 0, 16'h0, 16'h0, 0);
        cyc(0, 0, 1, 16'h0010, 16'hABCD, 0);
        idle(c_IDLE + 5, 0);
        cyc(0, 1, 0, 16'h0, 16'h0, 0);
        idle(3, 0);

        // Write coincident with the done edge
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'(i), 16'h0100, 0);
        cyc(0, 0, 1, 16'h0003, 16'hFCFF, 1);
        idle(20, 1);
        idle(2, 0);

        // Checksum-trailer image, then a truncated image
        cyc(0, 1, 0, 16'h0, 16'h0, 0);
        cyc(0, 0, 1, 16'h0000, 16'h0001, 0);
        cyc(0, 0, 1, 16'h0001, 16'h0002, 0);
        cyc(0, 0, 1, 16'h0002, 16'hFFFD, 0);
        idle(4, 1);
        idle(2, 0);
        cyc(0, 1, 0, 16'h0, 16'h0, 0);
        cyc(0, 0, 1, 16'h0000, 16'h0001, 0);
        cyc(0, 0, 1, 16'h0001, 16'h0002, 0);
        idle(4, 1);
        idle(2, 0);

        // Randomised traffic with periodic quiet windows
        done_lvl = 0;
        for (int k = 0; k < 1500; k++) begin
            r   = ($urandom_range(0, 499) == 0);
            lr  = ($urandom_range(0, 39) == 0);
            wen = ((k % 300) < 200) ? 1'($urandom) : 1'b0;
            adr = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'h4000, 16'hFFFF))
                                              : 16'($urandom_range(0, c_DEPTH - 1));
            if ($urandom_range(0, 29) == 0) done_lvl = ~done_lvl;
            cyc(r, lr, wen, adr, 16'($urandom), done_lvl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
